// File: rtl/candy_wb_sched_pkg.sv
// Shared constants and helpers for the candy write-back scheduler.
// Arbitration mode is selected by WB_RR_ARB_EN (see candy_wb_arb).
package candy_wb_sched_pkg;

    localparam int WB_REQ_NUM = 3;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_LOAD = 2'd1,
        WB_SRC_MDU  = 2'd2
    } wb_src_e;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic                  RST_ENABLE   = 1'b1;
    localparam logic                  WRITE_ENABLE = 1'b1;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/candy_wb_arb.sv
// NREQ-wide one-hot grant generator for the write-back port.
// WB_RR_ARB_EN defined: round-robin; undefined: fixed priority, index 0 highest.
module candy_wb_arb
    import candy_wb_sched_pkg::*;
#(
    parameter int NREQ = WB_REQ_NUM
) (
`ifdef WB_RR_ARB_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o
);

    logic found;

`ifdef WB_RR_ARB_EN
    localparam int PW = ptr_width(NREQ);

    // ptr_q holds the index where the next search begins (one past the last grant)
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == PW'(NREQ-1)) ? '0 : idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/candy_wb_sched.sv
// Write-back scheduler: arbitrates result sources onto the single register-file
// write port and tracks outstanding writes to stall RAW/WAW hazards (WB_RR_ARB_EN selects rr arbitration).
module candy_wb_sched
    import candy_wb_sched_pkg::*;
#(
    parameter int NREQ   = WB_REQ_NUM,
    parameter int REG_AW = REG_ADDR_W,
    parameter int DW     = REG_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        wb_valid_i,
    input  logic [NREQ*REG_AW-1:0] wb_addr_i,
    input  logic [NREQ*DW-1:0]     wb_data_i,
    output logic [NREQ-1:0]        wb_ready_o,
    input  logic                   issue_valid_i,
    input  logic [REG_AW-1:0]      issue_waddr_i,
    input  logic                   re1_i,
    input  logic                   re2_i,
    input  logic [REG_AW-1:0]      raddr1_i,
    input  logic [REG_AW-1:0]      raddr2_i,
    output logic                   issue_stall_o,
    output logic                   we_o,
    output logic [REG_AW-1:0]      waddr_o,
    output logic [DW-1:0]          wdata_o
);

    localparam int NREG = 1 << REG_AW;

    logic [NREQ-1:0]   grant;
    logic [REG_AW-1:0] src_addr [NREQ];
    logic [DW-1:0]     src_data [NREQ];
    logic [REG_AW-1:0] sel_addr;
    logic [DW-1:0]     sel_data;
    logic              xfer;
    logic              issue_acc;

    logic              we_q, we_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
        assign src_addr[gi] = wb_addr_i[gi*REG_AW +: REG_AW];
        assign src_data[gi] = wb_data_i[gi*DW +: DW];
    end

    candy_wb_arb #(.NREQ(NREQ)) u_arb (
`ifdef WB_RR_ARB_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .req_i   (wb_valid_i),
        .grant_o (grant)
    );

    // No grant may be seen while reset is held; sources re-present afterwards
    assign wb_ready_o = rst ? '0 : grant;
    assign xfer       = |wb_ready_o;

    always_comb begin
        sel_addr = '0;
        sel_data = ZERO_WORD;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr = sel_addr | ({REG_AW{wb_ready_o[i]}} & src_addr[i]);
            sel_data = sel_data | ({DW{wb_ready_o[i]}} & src_data[i]);
        end
    end

    // The register file forwards the in-flight write, so it does not count as a hazard
    function automatic logic hit(input logic re, input logic [REG_AW-1:0] a, input logic busy_bit,
                                 input logic we, input logic [REG_AW-1:0] wa);
        return re && (a != '0) && busy_bit && !(we && (wa == a));
    endfunction

    assign issue_stall_o = hit(re1_i, raddr1_i, busy_q[raddr1_i], we_q, waddr_q)
                         | hit(re2_i, raddr2_i, busy_q[raddr2_i], we_q, waddr_q)
                         | (issue_valid_i && hit(1'b1, issue_waddr_i, busy_q[issue_waddr_i], we_q, waddr_q));

    assign issue_acc = issue_valid_i && !issue_stall_o && (issue_waddr_i != '0);

    always_comb begin
        // a granted write to r0 is consumed but never reaches the register file
        we_d    = xfer && (sel_addr != '0);
        waddr_d = we_d ? sel_addr : waddr_q;
        wdata_d = we_d ? sel_data : wdata_q;
        busy_d  = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[issue_waddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= ZERO_WORD;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_candy_wb_sched.sv
// Scoreboard bench for candy_wb_sched: a cycle-level reference model predicts grants,
// stalls and register writes; a separate monitor checks every write on the port.
module tb_candy_wb_sched;

    localparam int NREQ   = 3;
    localparam int REG_AW = 5;
    localparam int DW     = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        wb_valid_i;
    logic [NREQ*REG_AW-1:0] wb_addr_i;
    logic [NREQ*DW-1:0]     wb_data_i;
    logic [NREQ-1:0]        wb_ready_o;
    logic                   issue_valid_i;
    logic [REG_AW-1:0]      issue_waddr_i;
    logic                   re1_i, re2_i;
    logic [REG_AW-1:0]      raddr1_i, raddr2_i;
    logic                   issue_stall_o;
    logic                   we_o;
    logic [REG_AW-1:0]      waddr_o;
    logic [DW-1:0]          wdata_o;

    candy_wb_sched #(.NREQ(NREQ), .REG_AW(REG_AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .re1_i         (re1_i),
        .re2_i         (re2_i),
        .raddr1_i      (raddr1_i),
        .raddr2_i      (raddr2_i),
        .issue_stall_o (issue_stall_o),
        .we_o          (we_o),
        .waddr_o       (waddr_o),
        .wdata_o       (wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    wr_t         exp_q[$];
    wr_t         w;

    // pending source requests (held until granted)
    bit          src_v [NREQ];
    logic [4:0]  src_a [NREQ];
    logic [31:0] src_d [NREQ];

    // reference model state
    bit          busy_m [32];
    bit          m_we;
    logic [4:0]  m_waddr;
`ifdef WB_RR_ARB_EN
    int          rr_start;
`endif

    logic [NREQ-1:0] last_ready;
    logic            last_stall;
    logic            last_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_src();
        for (int k = 0; k < NREQ; k++) begin
            wb_valid_i[k]                  = src_v[k];
            wb_addr_i[k*REG_AW +: REG_AW]  = src_a[k];
            wb_data_i[k*DW +: DW]          = src_d[k];
        end
    endtask

    task automatic set_issue(input bit v, input int a);
        issue_valid_i = v;
        issue_waddr_i = REG_AW'(a);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
`ifdef WB_RR_ARB_EN
        rr_start = 0;
`endif
        exp_q.delete();
        for (int k = 0; k < NREQ; k++) src_v[k] = 1'b0;
    endtask

    function automatic bit m_hit(input logic [4:0] a, input bit re);
        return re && (a != 0) && busy_m[a] && !(m_we && (m_waddr == a));
    endfunction

    function automatic int m_grant();
`ifdef WB_RR_ARB_EN
        for (int i = 0; i < NREQ; i++) begin
            if (src_v[(rr_start + i) % NREQ]) return (rr_start + i) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (src_v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // One cycle: called just after a rising edge with inputs prepared.
    task automatic step();
        int              g;
        bit              stall_e;
        logic [NREQ-1:0] gvec;
        apply_src();
        @(negedge clk);
        g       = m_grant();
        gvec    = (g >= 0) ? NREQ'(1 << g) : '0;
        stall_e = m_hit(raddr1_i, re1_i) | m_hit(raddr2_i, re2_i)
                | (issue_valid_i && m_hit(issue_waddr_i, 1'b1));
        last_ready = wb_ready_o;
        last_stall = issue_stall_o;
        last_we    = we_o;
        check("grant", wb_ready_o, gvec);
        check("stall", issue_stall_o, stall_e);
        if (m_we) busy_m[m_waddr] = 1'b0;
        if (issue_valid_i && !stall_e && issue_waddr_i != 0) busy_m[issue_waddr_i] = 1'b1;
        m_we = 1'b0;
        if (g >= 0) begin
            if (src_a[g] != 0) begin
                exp_q.push_back('{due: cyc + 1, a: src_a[g], d: src_d[g]});
                m_we    = 1'b1;
                m_waddr = src_a[g];
            end
            src_v[g] = 1'b0;
`ifdef WB_RR_ARB_EN
            rr_start = (g + 1) % NREQ;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        set_issue(1'b0, 0);
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;
        model_reset();
        apply_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    // Write-port monitor: every we_o=1 must match the oldest expected write due now
    always @(negedge clk) begin
        if (!rst) begin
            if (we_o) begin
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got we_o=1 waddr=%0d expected no write (cycle %0d)", waddr_o, cyc);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", waddr_o, w.a);
                    check("wr_data", wdata_o, w.d);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                w = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL wr_missing: got we_o=0 expected write r%0d=%0h (cycle %0d)", w.a, w.d, cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_issue(1'b0, 0);
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            src_v[k] = 1'b1; src_a[k] = 5'(k + 1); src_d[k] = 32'hA0 + k;
        end
        apply_src();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_ready", wb_ready_o, 0);
        model_reset();
        apply_src();
        rst = 1'b0;

        // RAW on r7 resolved by a source-1 write-back
        set_issue(1'b1, 7);
        step();
        set_issue(1'b0, 0);
        re1_i = 1'b1; raddr1_i = 5'd7;
        src_v[1] = 1'b1; src_a[1] = 5'd7; src_d[1] = 32'hDEADBEEF;
        step();
        check("t2_raw_stall", last_stall, 1);
        check("t2_grant", last_ready, 3'b010);
        step();
        check("t2_inflight_we", last_we, 1);
        check("t2_inflight_stall", last_stall, 0);
        step();
        check("t2_cleared_stall", last_stall, 0);

        // All sources valid from a fresh arbiter state
        reset_pulse();
        for (int k = 0; k < NREQ; k++) begin
            src_v[k] = 1'b1; src_a[k] = 5'(10 + k); src_d[k] = $urandom;
        end
        step(); check("t3_g0", last_ready, 3'b001);
        step(); check("t3_g1", last_ready, 3'b010);
        check("t3_we_a", last_we, 1);
        step(); check("t3_g2", last_ready, 3'b100);
        check("t3_we_b", last_we, 1);
        for (int k = 0; k < NREQ; k++) begin
            src_v[k] = 1'b1; src_a[k] = 5'(13 + k); src_d[k] = $urandom;
        end
        step(); check("t4_wrap", last_ready, 3'b001);
        check("t3_we_c", last_we, 1);
        step();
        src_v[0] = 1'b1; src_a[0] = 5'd20; src_d[0] = $urandom;
        step();
        src_v[0] = 1'b1; src_a[0] = 5'd21; src_d[0] = $urandom;
        step(); check("t4_src0_only", last_ready, 3'b001);
        src_v[0] = 1'b1; src_a[0] = 5'd22; src_d[0] = $urandom;
        src_v[1] = 1'b1; src_a[1] = 5'd23; src_d[1] = $urandom;
        src_v[2] = 1'b1; src_a[2] = 5'd24; src_d[2] = $urandom;
        step();
`ifdef WB_RR_ARB_EN
        check("t4_after0", last_ready, 3'b010);
`else
        check("t4_after0", last_ready, 3'b001);
`endif
        repeat (3) step();

        // WAW on r3, then issue coinciding with the r3 write-back
        reset_pulse();
        set_issue(1'b1, 3);
        step();
        step(); check("t5_waw_stall", last_stall, 1);
        set_issue(1'b0, 0);
        src_v[0] = 1'b1; src_a[0] = 5'd3; src_d[0] = 32'h33;
        step();
        set_issue(1'b1, 3);
        step();
        check("t5_same_cycle_stall", last_stall, 0);
        check("t5_same_cycle_we", last_we, 1);
        set_issue(1'b0, 0);
        re1_i = 1'b1; raddr1_i = 5'd3;
        step(); check("t5_set_wins", last_stall, 1);
        re1_i = 1'b0;

        // write to r0 is consumed but dropped; r0 never stalls
        src_v[2] = 1'b1; src_a[2] = 5'd0; src_d[2] = 32'h1;
        set_issue(1'b1, 0); re1_i = 1'b1; raddr1_i = 5'd0;
        step();
        check("t6_ready", last_ready, 3'b100);
        check("t6_r0_stall", last_stall, 0);
        set_issue(1'b0, 0); re1_i = 1'b0;
        step(); check("t6_no_we", last_we, 0);

        // reset in the middle of a transfer with busy[5] set
        reset_pulse();
        set_issue(1'b1, 5);
        step();
        set_issue(1'b0, 0);
        re1_i = 1'b1; raddr1_i = 5'd5;
        src_v[0] = 1'b1; src_a[0] = 5'd9; src_d[0] = 32'h12345678;
        step();
        check("t1_busy5", last_stall, 1);
        check("t1_pre_we", we_o, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_we", we_o, 0);
        check("t1_rst_wdata", wdata_o, 0);
        check("t1_rst_ready", wb_ready_o, 0);
        reset_pulse();
        re1_i = 1'b1; raddr1_i = 5'd5;
        step(); check("t1_post_stall", last_stall, 0);

        // randomized traffic
        repeat (400) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!src_v[k] && $urandom_range(0, 2) == 0) begin
                    src_v[k] = 1'b1;
                    src_a[k] = 5'($urandom_range(0, 7));
                    src_d[k] = $urandom;
                end
            end
            set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 7));
            re1_i    = $urandom_range(0, 1) == 1;
            re2_i    = $urandom_range(0, 1) == 1;
            raddr1_i = 5'($urandom_range(0, 7));
            raddr2_i = 5'($urandom_range(0, 7));
            step();
        end

        // drain outstanding requests
        set_issue(1'b0, 0); re1_i = 1'b0; re2_i = 1'b0;
        repeat (6) step();
        check("drain_queue", exp_q.size(), 0);
        check("drain_src", {src_v[0], src_v[1], src_v[2]}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
